// File: rtl/ssd_score_scanner.sv
// Seven-segment score driver: takes a binary score over valid/ready, converts it to BCD
// one bit per clock, and scans NUM_DIGITS active-low digits off a free-running prescaler.
module ssd_score_scanner #(
    parameter int NUM_DIGITS    = 4,
    parameter int SCORE_W       = 10,
    parameter int SCAN_DIV      = 18,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  board_clk,
    input  logic                  Reset,
    input  logic [SCORE_W-1:0]    score_in,
    input  logic                  score_valid,
    output logic                  score_ready,
    input  logic                  display_en,
    output logic                  done,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [1:0]            dbg_state_o
);

    // Handshake: a score is taken on any clock edge where score_valid and score_ready are
    // both high; score_valid while score_ready is low is dropped, never queued.

    localparam int MIN_D = (SCORE_W + 2) / 3;
    localparam int INT_D = (NUM_DIGITS > MIN_D) ? NUM_DIGITS : MIN_D;
    localparam int BCD_W = INT_D * 4;
    localparam int DIG_W = NUM_DIGITS * 4;
    localparam int CNT_W = $clog2(SCORE_W);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t               state_q;
    logic [SCORE_W-1:0]   bin_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [BCD_W-1:0]     bcd_adj_d;
    logic [BCD_W-1:0]     bcd_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 carry_q;
    logic                 high_nz_d;
    logic [DIG_W-1:0]     digits_q;
    logic                 ready_q;
    logic                 done_q;
    logic                 ovf_q;

    logic [SCAN_DIV-1:0]  presc_q;
    logic [IDX_W-1:0]     idx_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]           seg_q;
    logic [6:0]           seg_d;
    logic [NUM_DIGITS-1:0] lead_zero_d;
    logic [3:0]           cur_digit_d;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Shift-add-3 step: correct every nibble >= 5, then shift in the next binary bit.
    always_comb begin
        bcd_adj_d = '0;
        for (int i = 0; i < INT_D; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            else
                bcd_adj_d[i*4 +: 4] = bcd_q[i*4 +: 4];
        end
        bcd_d = {bcd_adj_d[BCD_W-2:0], bin_q[SCORE_W-1]};
    end

    always_comb begin
        high_nz_d = carry_q;
        for (int i = NUM_DIGITS; i < INT_D; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0)
                high_nz_d = 1'b1;
        end
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            digits_q <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (score_valid) begin
                        bin_q   <= score_in;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        carry_q <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd_q   <= bcd_d;
                    bin_q   <= {bin_q[SCORE_W-2:0], 1'b0};
                    cnt_q   <= cnt_q + 1'b1;
                    // A carry out of the top nibble cannot occur for in-range widths; kept sticky as a guard.
                    carry_q <= carry_q | bcd_adj_d[BCD_W-1];
                    if (cnt_q == CNT_W'(SCORE_W - 1))
                        state_q <= S_COMMIT;
                end
                S_COMMIT: begin
                    done_q   <= 1'b1;
                    ovf_q    <= high_nz_d;
                    digits_q <= high_nz_d ? {NUM_DIGITS{4'd9}} : bcd_q[DIG_W-1:0];
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // lead_zero_d[k] is set when digit k and every digit above it are zero.
    always_comb begin
        logic zero_above;
        zero_above  = 1'b1;
        lead_zero_d = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above     = zero_above && (digits_q[k*4 +: 4] == 4'd0);
            lead_zero_d[k] = zero_above;
        end
        cur_digit_d = digits_q[idx_q*4 +: 4];
        if ((BLANK_LEADING != 0) && !ovf_q && (idx_q != '0) && lead_zero_d[idx_q])
            seg_d = 7'b1111111;
        else
            seg_d = decode(cur_digit_d);
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= 7'b1111111;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (&presc_q) begin
                if (idx_q == IDX_W'(NUM_DIGITS - 1))
                    idx_q <= '0;
                else
                    idx_q <= idx_q + 1'b1;
            end
            an_q  <= display_en ? ~(NUM_DIGITS'(1) << idx_q) : '1;
            seg_q <= seg_d;
        end
    end

    assign score_ready = ready_q;
    assign done        = done_q;
    assign overflow    = ovf_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = 1'b1;
    assign dbg_state_o = state_q;

endmodule
